csr_trap_unit: RTL and testbench

Machine-mode CSR file and trap sequencer sitting behind the instruction decoder. It consumes the decoder's system-instruction controls: CSR read/modify/write, exception raise with cause code, and return. It executes CSR accesses, enters traps, services mret and external interrupts, and hands a PC redirect and the privilege mode back to the pipeline. It also owns the cycle and retired-instruction counters.

---
 rtl/csr_trap_unit_pkg.sv | 56 +++++
 rtl/csr_trap_unit_if.sv | 33 +++
 rtl/csr_trap_unit_counter64.sv | 28 ++
 rtl/csr_trap_unit.sv | 187 ++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_trap_unit_pkg.sv
// Shared encodings for the machine-mode CSR file and trap sequencer:
// privilege levels, CSR addresses, cause codes and csr_op values.
package csr_trap_unit_pkg;

    typedef enum logic [1:0] {
        PRIV_USER    = 2'd0,
        PRIV_SUPERV  = 2'd1,
        PRIV_MACHINE = 2'd3
    } priv_e;

    typedef enum logic [1:0] {
        CSR_RW   = 2'd0,
        CSR_RS   = 2'd1,
        CSR_RC   = 2'd2,
        CSR_NONE = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2
    } state_e;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MRET      = 12'h302;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_ECALL_U = 32'd8;
    localparam logic [31:0] CAUSE_ECALL_S = 32'd9;
    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;

    // MXL = 1 (32-bit) with only the I extension present
    localparam logic [31:0] MISA_RV32I = 32'h4000_0100;

    function automatic logic csr_mapped(input logic [11:0] addr);
        case (addr)
            ADDR_MSTATUS, ADDR_MISA, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH,
            ADDR_MEPC, ADDR_MCAUSE, ADDR_MIP, ADDR_MCYCLE, ADDR_MINSTRET,
            ADDR_MCYCLEH, ADDR_MINSTRETH: csr_mapped = 1'b1;
            default:                      csr_mapped = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// Decoder-facing request/response bundle of the CSR and trap unit.
interface csr_trap_unit_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc;
    logic [11:0]     csr_addr;
    logic            csr_we;
    logic            atomic_wr;
    logic [1:0]      csr_op;
    logic            csr_src;
    logic [XLEN-1:0] rs1_val;
    logic [4:0]      zimm;
    logic            raise_excep;
    logic [3:0]      excep_code;
    logic            ret;
    logic            rd_valid;
    logic [XLEN-1:0] rd_data;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      mode;

    modport master (
        output in_valid, pc, csr_addr, csr_we, atomic_wr, csr_op, csr_src,
               rs1_val, zimm, raise_excep, excep_code, ret,
        input  in_ready, rd_valid, rd_data, redirect, redirect_pc, mode
    );

    modport slave (
        input  in_valid, pc, csr_addr, csr_we, atomic_wr, csr_op, csr_src,
               rs1_val, zimm, raise_excep, excep_code, ret,
        output in_ready, rd_valid, rd_data, redirect, redirect_pc, mode
    );
endinterface

// File: rtl/csr_trap_unit_counter64.sv
// Double-width event counter; a write to either half takes precedence
// over the increment and leaves the other half untouched that cycle.
module csr_counter64 #(parameter int W = 32) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         wr_lo,
    input  logic         wr_hi,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);
    logic [2*W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (wr_lo)
            count[W-1:0] <= wdata;
        else if (wr_hi)
            count[2*W-1:W] <= wdata;
        else if (inc)
            count <= count + {{(2*W-1){1'b0}}, 1'b1};
    end

    assign lo = count[W-1:0];
    assign hi = count[2*W-1:W];
endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap/return sequencer; architectural effects of a
// trap or mret land at acceptance, the following cycle issues the redirect.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           irq,
    input  logic           retire,
    csr_trap_unit_if.slave bus
);
    state_e          state, state_next;
    logic [1:0]      mode;
    logic            st_mie, st_mpie, meie;
    logic [1:0]      st_mpp;
    logic [XLEN-1:0] mtvec, mscratch, mepc, mcause;
    logic [XLEN-1:0] cycle_lo, cycle_hi, instret_lo, instret_hi;
    logic            rd_valid_q;
    logic [XLEN-1:0] rd_data_q;
    logic            in_ready, redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] src, csr_old, csr_new, trap_cause;

    logic accept, is_csr, wants_write, csr_illegal, ret_illegal, take_irq;
    logic take_trap, take_ret, do_csr, csr_write;

    assign accept      = bus.in_valid && state == ST_IDLE;
    assign src         = bus.csr_src ? {{(XLEN-5){1'b0}}, bus.zimm} : bus.rs1_val;
    assign is_csr      = bus.csr_op != CSR_NONE;
    assign wants_write = (bus.csr_op == CSR_RW && bus.csr_we) ||
                         ((bus.csr_op == CSR_RS || bus.csr_op == CSR_RC) && src != '0);
    assign csr_illegal = is_csr && (!csr_mapped(bus.csr_addr) ||
                         (wants_write && bus.csr_addr[11:10] == 2'b11) ||
                         (mode < bus.csr_addr[9:8]));
    assign ret_illegal = bus.ret && bus.csr_addr != ADDR_MRET;
    assign take_irq    = irq && st_mie && meie;
    assign take_trap   = accept && (take_irq || bus.raise_excep || csr_illegal || ret_illegal);
    assign take_ret    = accept && !take_trap && bus.ret;
    assign do_csr      = accept && !take_trap && !bus.ret && is_csr;
    assign csr_write   = do_csr && wants_write;
    assign trap_cause  = take_irq        ? CAUSE_MEI :
                         bus.raise_excep ? {{(XLEN-4){1'b0}}, bus.excep_code} : CAUSE_ILLEGAL;

    always_comb begin
        case (bus.csr_addr)
            ADDR_MSTATUS:   csr_old = {{(XLEN-13){1'b0}}, st_mpp, 3'b000, st_mpie, 3'b000, st_mie, 3'b000};
            ADDR_MISA:      csr_old = MISA_RV32I;
            ADDR_MIE:       csr_old = {{(XLEN-12){1'b0}}, meie, 11'b0};
            ADDR_MTVEC:     csr_old = mtvec;
            ADDR_MSCRATCH:  csr_old = mscratch;
            ADDR_MEPC:      csr_old = mepc;
            ADDR_MCAUSE:    csr_old = mcause;
            ADDR_MIP:       csr_old = {{(XLEN-12){1'b0}}, irq, 11'b0};
            ADDR_MCYCLE:    csr_old = cycle_lo;
            ADDR_MCYCLEH:   csr_old = cycle_hi;
            ADDR_MINSTRET:  csr_old = instret_lo;
            ADDR_MINSTRETH: csr_old = instret_hi;
            default:        csr_old = '0;
        endcase
    end

    always_comb begin
        case (bus.csr_op)
            CSR_RS:  csr_new = csr_old | src;
            CSR_RC:  csr_new = csr_old & ~src;
            default: csr_new = src;
        endcase
    end

    // misa and mip writes fall through the default and are silently dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode       <= PRIV_MACHINE;
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            st_mpp     <= PRIV_USER;
            meie       <= 1'b0;
            mtvec      <= {RESET_MTVEC[XLEN-1:2], 2'b00};
            mscratch   <= '0;
            mepc       <= '0;
            mcause     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            if (take_trap) begin
                mepc    <= {bus.pc[XLEN-1:2], 2'b00};
                mcause  <= trap_cause;
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
                st_mpp  <= mode;
                mode    <= PRIV_MACHINE;
            end else if (take_ret) begin
                mode    <= st_mpp;
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
                st_mpp  <= PRIV_USER;
            end else if (do_csr) begin
                if (bus.atomic_wr) begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= csr_old;
                end
                if (csr_write) begin
                    case (bus.csr_addr)
                        ADDR_MSTATUS: begin
                            st_mie  <= csr_new[3];
                            st_mpie <= csr_new[7];
                            st_mpp  <= csr_new[12:11];
                        end
                        ADDR_MIE:      meie     <= csr_new[11];
                        ADDR_MTVEC:    mtvec    <= {csr_new[XLEN-1:2], 2'b00};
                        ADDR_MSCRATCH: mscratch <= csr_new;
                        ADDR_MEPC:     mepc     <= {csr_new[XLEN-1:2], 2'b00};
                        ADDR_MCAUSE:   mcause   <= csr_new;
                        default:       ;
                    endcase
                end
            end
        end
    end

    csr_counter64 #(.W(XLEN)) u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (csr_write && bus.csr_addr == ADDR_MCYCLE),
        .wr_hi (csr_write && bus.csr_addr == ADDR_MCYCLEH),
        .wdata (csr_new),
        .lo    (cycle_lo),
        .hi    (cycle_hi)
    );

    csr_counter64 #(.W(XLEN)) u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .wr_lo (csr_write && bus.csr_addr == ADDR_MINSTRET),
        .wr_hi (csr_write && bus.csr_addr == ADDR_MINSTRETH),
        .wdata (csr_new),
        .lo    (instret_lo),
        .hi    (instret_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (take_trap)
                    state_next = ST_TRAP;
                else if (take_ret)
                    state_next = ST_RET;
            end
            ST_TRAP: begin
                redirect    = 1'b1;
                redirect_pc = {mtvec[XLEN-1:2], 2'b00};
                state_next  = ST_IDLE;
            end
            ST_RET: begin
                redirect    = 1'b1;
                redirect_pc = mepc;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.in_ready    = in_ready;
    assign bus.redirect    = redirect;
    assign bus.redirect_pc = redirect_pc;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.mode        = mode;
endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: a transaction-level model of the CSR file
// is compared every cycle, plus hand-computed readback expectations.
module tb_csr_trap_unit;
    logic clk = 1'b0;
    logic rst_n;
    logic irq;
    logic retire;
    int   checks = 0;
    int   errors = 0;

    csr_trap_unit_if #(.XLEN(32)) bus ();

    csr_trap_unit #(.XLEN(32), .RESET_MTVEC(32'h0000_0100)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq    (irq),
        .retire (retire),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mstatus/mie kept as masked words, state as 0 idle / 1 trap / 2 ret
    int          m_st;
    logic [1:0]  m_mode;
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_rdd;
    logic [63:0] m_cycle, m_instret, n_cycle, n_instret;
    logic        m_rdv;
    logic [31:0] m_src, m_old, m_new;
    logic        m_found, m_wr;

    function automatic logic [32:0] modelRead(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, m_mstatus};
            12'h301: return {1'b1, 32'h4000_0100};
            12'h304: return {1'b1, m_mie};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h344: return {1'b1, irq ? 32'h800 : 32'h0};
            12'hB00: return {1'b1, m_cycle[31:0]};
            12'hB80: return {1'b1, m_cycle[63:32]};
            12'hB02: return {1'b1, m_instret[31:0]};
            12'hB82: return {1'b1, m_instret[63:32]};
            default: return 33'h0;
        endcase
    endfunction

    task automatic modelTrap(input logic [31:0] cause);
        m_mepc          = bus.pc & ~32'h3;
        m_mcause        = cause;
        m_mstatus[7]    = m_mstatus[3];
        m_mstatus[3]    = 1'b0;
        m_mstatus[12:11] = m_mode;
        m_mode          = 2'd3;
        m_st            = 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_mode = 2'd3; m_mstatus = 0; m_mie = 0; m_mtvec = 32'h100;
            m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cycle = 0; m_instret = 0;
            m_rdv = 0; m_rdd = 0;
        end else begin
            n_cycle   = m_cycle + 64'd1;
            n_instret = m_instret + {63'd0, retire};
            m_rdv     = 1'b0;
            if (m_st != 0) begin
                m_st = 0;
            end else if (bus.in_valid) begin
                m_src   = bus.csr_src ? {27'd0, bus.zimm} : bus.rs1_val;
                {m_found, m_old} = modelRead(bus.csr_addr);
                m_wr    = (bus.csr_op == 2'd0 && bus.csr_we) ||
                          ((bus.csr_op == 2'd1 || bus.csr_op == 2'd2) && m_src != 0);
                if (irq && m_mstatus[3] && m_mie[11])
                    modelTrap(32'h8000_000B);
                else if (bus.raise_excep)
                    modelTrap({28'd0, bus.excep_code});
                else if ((bus.csr_op != 2'd3 && (!m_found || (m_wr && bus.csr_addr[11:10] == 2'b11) ||
                          m_mode < bus.csr_addr[9:8])) || (bus.ret && bus.csr_addr != 12'h302))
                    modelTrap(32'd2);
                else if (bus.ret) begin
                    m_mode           = m_mstatus[12:11];
                    m_mstatus[3]     = m_mstatus[7];
                    m_mstatus[7]     = 1'b1;
                    m_mstatus[12:11] = 2'd0;
                    m_st             = 2;
                end else if (bus.csr_op != 2'd3) begin
                    if (bus.atomic_wr) begin
                        m_rdv = 1'b1;
                        m_rdd = m_old;
                    end
                    m_new = (bus.csr_op == 2'd1) ? (m_old | m_src) :
                            (bus.csr_op == 2'd2) ? (m_old & ~m_src) : m_src;
                    if (m_wr) begin
                        case (bus.csr_addr)
                            12'h300: m_mstatus  = m_new & 32'h1888;
                            12'h304: m_mie      = m_new & 32'h800;
                            12'h305: m_mtvec    = m_new & ~32'h3;
                            12'h340: m_mscratch = m_new;
                            12'h341: m_mepc     = m_new & ~32'h3;
                            12'h342: m_mcause   = m_new;
                            12'hB00: n_cycle    = {m_cycle[63:32], m_new};
                            12'hB80: n_cycle    = {m_new, m_cycle[31:0]};
                            12'hB02: n_instret  = {m_instret[63:32], m_new};
                            12'hB82: n_instret  = {m_new, m_instret[31:0]};
                            default: ;
                        endcase
                    end
                end
            end
            m_cycle   = n_cycle;
            m_instret = n_instret;
        end
    end

    always @(negedge clk) begin
        checkOutput("cmp_in_ready", {31'd0, bus.in_ready}, {31'd0, m_st == 0});
        checkOutput("cmp_redirect", {31'd0, bus.redirect}, {31'd0, m_st != 0});
        checkOutput("cmp_redirect_pc", bus.redirect_pc,
                    (m_st == 1) ? m_mtvec : (m_st == 2) ? m_mepc : 32'h0);
        checkOutput("cmp_mode", {30'd0, bus.mode}, {30'd0, m_mode});
        checkOutput("cmp_rd_valid", {31'd0, bus.rd_valid}, {31'd0, m_rdv});
        checkOutput("cmp_rd_data", bus.rd_data, m_rdd);
    end

    task automatic clearInputs();
        bus.in_valid = 0; bus.pc = 0; bus.csr_addr = 0; bus.csr_we = 0; bus.atomic_wr = 0;
        bus.csr_op = 2'd3; bus.csr_src = 0; bus.rs1_val = 0; bus.zimm = 0;
        bus.raise_excep = 0; bus.excep_code = 0; bus.ret = 0;
    endtask

    // Present one request once the unit is ready; returns 1 time unit after the accepting edge
    task automatic applyStimulus(input logic [11:0] addr, input logic [1:0] op, input logic zsel,
                                 input logic [31:0] val, input logic aw, input logic exc,
                                 input logic [3:0] code, input logic r, input logic [31:0] p);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout actual=0 expected=1 at %0t", $time);
        end
        bus.in_valid = 1; bus.csr_addr = addr; bus.csr_op = op; bus.csr_src = zsel;
        bus.rs1_val = zsel ? 32'h0 : val; bus.zimm = val[4:0]; bus.csr_we = (op == 2'd0);
        bus.atomic_wr = aw; bus.raise_excep = exc; bus.excep_code = code; bus.ret = r; bus.pc = p;
        @(posedge clk); #1;
        clearInputs();
    endtask

    task automatic readCheck(input string name, input logic [11:0] addr, input logic [31:0] exp);
        applyStimulus(addr, 2'd1, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
        checkOutput(name, bus.rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        clearInputs();
        rst_n = 0; irq = 0; retire = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("rst_mode", {30'd0, bus.mode}, 32'd3);
        checkOutput("rst_redirect", {31'd0, bus.redirect}, 32'd0);
        checkOutput("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        applyStimulus(12'h340, 2'd0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'd0, 1'b0, 32'h10);
        checkOutput("rw_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
        checkOutput("rw_old", bus.rd_data, 32'h0);
        readCheck("rs_zero_read", 12'h340, 32'hDEAD_BEEF);
        readCheck("rs_zero_nowrite", 12'h340, 32'hDEAD_BEEF);
        readCheck("misa", 12'h301, 32'h4000_0100);
        applyStimulus(12'h340, 2'd2, 1'b1, 32'h0F, 1'b1, 1'b0, 4'd0, 1'b0, 32'h14);
        readCheck("rc_zimm", 12'h340, 32'hDEAD_BEE0);
        applyStimulus(12'h340, 2'd1, 1'b1, 32'h11, 1'b1, 1'b0, 4'd0, 1'b0, 32'h18);
        readCheck("rs_zimm", 12'h340, 32'hDEAD_BEF1);

        applyStimulus(12'h341, 2'd0, 1'b0, 32'h404, 1'b1, 1'b0, 4'd0, 1'b0, 32'h20);
        applyStimulus(12'h300, 2'd0, 1'b0, 32'h80, 1'b1, 1'b0, 4'd0, 1'b0, 32'h24);
        applyStimulus(12'h302, 2'd3, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 32'h28);
        checkOutput("mret_redirect", {31'd0, bus.redirect}, 32'd1);
        checkOutput("mret_pc", bus.redirect_pc, 32'h404);
        checkOutput("mret_mode", {30'd0, bus.mode}, 32'd0);

        applyStimulus(12'h000, 2'd3, 1'b0, 32'h0, 1'b0, 1'b1, 4'd8, 1'b0, 32'h200);
        checkOutput("exc_redirect_pc", bus.redirect_pc, 32'h100);
        checkOutput("exc_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("exc_mode", {30'd0, bus.mode}, 32'd3);
        readCheck("exc_mepc", 12'h341, 32'h200);
        readCheck("exc_mcause", 12'h342, 32'd8);
        readCheck("exc_mstatus", 12'h300, 32'h80);

        applyStimulus(12'h304, 2'd0, 1'b0, 32'h800, 1'b1, 1'b0, 4'd0, 1'b0, 32'h30);
        applyStimulus(12'h300, 2'd0, 1'b0, 32'h8, 1'b1, 1'b0, 4'd0, 1'b0, 32'h34);
        irq = 1;
        applyStimulus(12'h340, 2'd0, 1'b0, 32'h1234, 1'b1, 1'b0, 4'd0, 1'b0, 32'h80);
        checkOutput("irq_redirect", {31'd0, bus.redirect}, 32'd1);
        readCheck("irq_no_exec", 12'h340, 32'hDEAD_BEF1);
        readCheck("irq_mcause", 12'h342, 32'h8000_000B);
        readCheck("irq_mepc", 12'h341, 32'h80);
        readCheck("irq_mstatus", 12'h300, 32'h1880);
        readCheck("mip_level", 12'h344, 32'h800);
        irq = 0;

        applyStimulus(12'h340, 2'd0, 1'b0, 32'h5555, 1'b0, 1'b0, 4'd0, 1'b0, 32'h38);
        checkOutput("no_atomic_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        readCheck("no_atomic_write", 12'h340, 32'h5555);

        applyStimulus(12'hB00, 2'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd0, 1'b0, 32'h40);
        readCheck("mcycle_lo", 12'hB00, 32'hFFFF_FFFF);
        readCheck("mcycle_carry", 12'hB80, 32'd1);
        retire = 1;
        applyStimulus(12'hB02, 2'd0, 1'b0, 32'd10, 1'b1, 1'b0, 4'd0, 1'b0, 32'h44);
        repeat (2) @(posedge clk);
        #1 retire = 0;
        readCheck("minstret", 12'hB02, 32'd12);

        applyStimulus(12'h7C0, 2'd1, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0, 32'h50);
        checkOutput("unmapped_redirect", {31'd0, bus.redirect}, 32'd1);
        readCheck("unmapped_mcause", 12'h342, 32'd2);
        applyStimulus(12'h342, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0, 32'h54);
        applyStimulus(12'h105, 2'd3, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 32'h58);
        readCheck("bad_ret_mcause", 12'h342, 32'd2);
        applyStimulus(12'h341, 2'd0, 1'b0, 32'h300, 1'b1, 1'b0, 4'd0, 1'b0, 32'h5C);
        applyStimulus(12'h300, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0, 32'h60);
        applyStimulus(12'h302, 2'd3, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 32'h64);
        applyStimulus(12'h340, 2'd1, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0, 32'h303);
        checkOutput("user_access_redirect", {31'd0, bus.redirect}, 32'd1);
        readCheck("user_access_mepc", 12'h341, 32'h300);
        readCheck("user_access_mcause", 12'h342, 32'd2);

        applyStimulus(12'h000, 2'd3, 1'b0, 32'h0, 1'b0, 1'b1, 4'd11, 1'b0, 32'h70);
        rst_n = 0;
        #1;
        checkOutput("midtrap_redirect", {31'd0, bus.redirect}, 32'd0);
        checkOutput("midtrap_redirect_pc", bus.redirect_pc, 32'h0);
        checkOutput("midtrap_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("midtrap_mode", {30'd0, bus.mode}, 32'd3);
        checkOutput("midtrap_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        checkOutput("midtrap_rd_data", bus.rd_data, 32'h0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        readCheck("post_rst_mscratch", 12'h340, 32'h0);
        readCheck("post_rst_mtvec", 12'h305, 32'h100);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
